// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, frame levels and parity helper for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam int   MAX_BITS  = 8;

  // Returns the parity bit that makes popcount(d) + p odd
  function automatic logic odd_parity(input logic [MAX_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: oversampling counter giving a mid-bit sample tick and an end-of-period tick
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic sample_tick,
  output logic period_tick
);

  localparam int W = $clog2(OVERSAMPLE);

  logic [W-1:0] cnt;

  assign sample_tick = run && cnt == W'(OVERSAMPLE / 2 - 1);
  assign period_tick = run && cnt == W'(OVERSAMPLE - 1);

  // Free-running bit-period counter, zeroed on restart or when idle
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (restart || !run || period_tick) ? '0 : cnt + W'(1);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: 4-bit odd-parity UART receiver with holding register and error accounting
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_status,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int IW = $clog2(DATA_BITS + 1);

  state_t               state, nxt;
  logic                 rx_meta, rx_s, rx_d;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_ok, fall;
  logic                 restart, sample_tick, period_tick;
  logic                 shift, cap_par, load, perr, ferr;
  logic [CNT_W-1:0]     cnt_base;

  assign fall     = rx_d & ~rx_s;
  assign par_ok   = odd_parity(MAX_BITS'(shreg)) == par_bit;
  assign cnt_base = clr_status ? '0 : err_cnt;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .run         (state != IDLE),
    .sample_tick (sample_tick),
    .period_tick (period_tick)
  );

  // Synchronise the raw line; idle level is high so no false edge leaves reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rx_meta, rx_s, rx_d} <= 3'b111;
    else {rx_meta, rx_s, rx_d} <= {rx_in, rx_meta, rx_s};

  // FSM state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;

  // Next state and per-cycle strobes; disable overrides everything
  always_comb begin
    nxt     = state;
    restart = 1'b0;
    shift   = 1'b0;
    cap_par = 1'b0;
    load    = 1'b0;
    perr    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE:   if (fall) begin
        restart = 1'b1;
        nxt     = START;
      end
      START:  if (sample_tick) nxt = (rx_s == START_LVL) ? DATA : IDLE;
      DATA:   if (sample_tick) begin
        shift = 1'b1;
        nxt   = (bit_idx == IW'(DATA_BITS - 1)) ? PARITY : DATA;
      end
      PARITY: if (sample_tick) begin
        cap_par = 1'b1;
        nxt     = STOP;
      end
      STOP:   if (sample_tick) begin
        ferr    = rx_s != STOP_LVL;
        perr    = !ferr && !par_ok;
        load    = !ferr && par_ok;
        restart = ferr;
        nxt     = ferr ? BREAK : IDLE;
      end
      BREAK:  begin
        restart = !rx_s;
        nxt     = (period_tick && rx_s) ? IDLE : BREAK;
      end
      default: nxt = IDLE;
    endcase
    if (!enable) begin
      nxt     = IDLE;
      restart = 1'b1;
      shift   = 1'b0;
      cap_par = 1'b0;
      load    = 1'b0;
      perr    = 1'b0;
      ferr    = 1'b0;
    end
  end

  // Data bit index, shift register and captured parity bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      bit_idx <= (!enable || state != DATA) ? '0 : bit_idx + IW'(shift);
      shreg   <= shift ? {rx_s, shreg[DATA_BITS-1:1]} : shreg;
      par_bit <= cap_par ? rx_s : par_bit;
    end

  // Holding register: a same-cycle accept frees the slot for the incoming word
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (load && (!rx_valid || rx_ready)) begin
      rx_data  <= shreg;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) rx_valid <= 1'b0;

  // Error pulses, sticky overrun and saturating error counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      parity_err <= perr;
      frame_err  <= ferr;
      overrun    <= (overrun & ~clr_status) | (load & rx_valid & ~rx_ready);
      err_cnt    <= cnt_base + CNT_W'((perr || ferr) && !(&cnt_base));
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed self-checking bench for the UART receive controller
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0, reset = 1'b0, enable = 1'b1, rx_in = 1'b1;
  logic       rx_ready = 1'b1, clr_status = 1'b0;
  logic [3:0] rx_data;
  logic [7:0] err_cnt;
  logic       rx_valid, parity_err, frame_err, overrun;
  logic       prev_valid = 1'b0;
  logic [6:0] fr;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, rise_cyc = -1, n_perr = 0, n_ferr = 0, n_vcyc = 0;
  int s, v0;

  uart_rx_frame_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_status (clr_status),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled away from the active edge
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_valid) n_vcyc <= n_vcyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                            input int rdy_at = -1, input int clr_at = -1);
    logic [6:0] f;
    f = {stop, p, d, 1'b0};
    for (int k = 0; k < 112; k++) begin
      rx_in = f[k/16];
      if (rdy_at >= 0) rx_ready = (k == rdy_at);
      if (clr_at >= 0) clr_status = (k == clr_at);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_errcnt", err_cnt, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    s = cyc; v0 = n_vcyc;
    send_frame(4'b1011, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t1_latency", rise_cyc, s + 107);
    chk("t1_valid_1cyc", n_vcyc - v0, 1);
    chk("t1_data", rx_data, 4'hB);
    chk("t1_no_perr", n_perr, 0);
    chk("t1_no_ferr", n_ferr, 0);

    send_frame(4'b0101, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_perr", n_perr, 1);
    chk("t2_errcnt", err_cnt, 1);
    chk("t2_no_valid", n_vcyc - v0, 1);
    chk("t2_valid_low", rx_valid, 0);

    send_frame(4'b0011, 1'b1, 1'b0);
    chk("t3_ferr", n_ferr, 1);
    chk("t3_perr_unchanged", n_perr, 1);
    chk("t3_errcnt", err_cnt, 2);
    repeat (40) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    s = cyc;
    send_frame(4'b0110, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_after_break_data", rx_data, 4'h6);
    chk("t3_after_break_lat", rise_cyc, s + 107);

    rx_ready = 1'b0;
    send_frame(4'h1, 1'b0, 1'b1);
    send_frame(4'h2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_valid", rx_valid, 1);
    chk("t4_data_kept", rx_data, 4'h1);
    chk("t4_overrun", overrun, 1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    chk("t4_clr_overrun", overrun, 0);
    chk("t4_clr_errcnt", err_cnt, 0);
    chk("t4_valid_held", rx_valid, 1);

    send_frame(4'h4, 1'b0, 1'b1, 106);
    repeat (2) @(negedge clk);
    chk("t4b_swap_data", rx_data, 4'h4);
    chk("t4b_swap_valid", rx_valid, 1);
    chk("t4b_no_overrun", overrun, 0);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4b_drained", rx_valid, 0);

    v0 = n_vcyc;
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_glitch_valid", rx_valid, 0);
    chk("t5_glitch_nvalid", n_vcyc - v0, 0);
    chk("t5_glitch_perr", n_perr, 1);
    chk("t5_glitch_ferr", n_ferr, 1);
    enable = 1'b0;
    send_frame(4'b1011, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_disabled_novalid", n_vcyc - v0, 0);
    enable = 1'b1;
    repeat (5) @(negedge clk);

    repeat (260) send_frame(4'b0101, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_saturate", err_cnt, 8'd255);
    chk("t6_perr_count", n_perr, 261);
    send_frame(4'b0101, 1'b0, 1'b1, -1, 106);
    repeat (2) @(negedge clk);
    chk("t6_clr_plus_err", err_cnt, 1);

    fr = {1'b1, 1'b0, 4'b1011, 1'b0};
    for (int k = 0; k < 40; k++) begin
      rx_in = fr[k/16];
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_errcnt", err_cnt, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_pulses", {parity_err, frame_err}, 0);
    rx_in = 1'b1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    s = cyc;
    send_frame(4'b1001, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_post_rst_data", rx_data, 4'h9);
    chk("t6_post_rst_lat", rise_cyc, s + 107);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
